// File: rtl/psum_adder_core_if.sv
`default_nettype none
// ============================================================================
// Module   : psum_adder_core_if
// Purpose  : Handshake bundle between the psum depacketizer, the three-way
//            psum reduction core and the output packetizer.
// Revision : 1.0 - initial release
// ============================================================================
interface psum_adder_core_if #(
  parameter int DWIDTH = 8
);
  logic [DWIDTH-1:0] in0_data;
  logic [DWIDTH-1:0] in1_data;
  logic [DWIDTH-1:0] in2_data;
  logic              in0_valid;
  logic              in1_valid;
  logic              in2_valid;
  logic              in0_ready;
  logic              in1_ready;
  logic              in2_ready;
  logic [DWIDTH-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        q_full;
  logic [2:0]        q_empty;

  modport master (
    output in0_data, in1_data, in2_data,
    output in0_valid, in1_valid, in2_valid,
    output out_ready,
    input  in0_ready, in1_ready, in2_ready,
    input  out_data, out_valid, q_full, q_empty
  );

  modport slave (
    input  in0_data, in1_data, in2_data,
    input  in0_valid, in1_valid, in2_valid,
    input  out_ready,
    output in0_ready, in1_ready, in2_ready,
    output out_data, out_valid, q_full, q_empty
  );
endinterface
`default_nettype wire

// File: rtl/psum_adder_core.sv
`default_nettype none
// ============================================================================
// Module   : psum_adder_core
// Purpose  : Buffers psums from three PEs and emits one saturated sum of
//            NACC three-way reductions per output word.
// Revision : 1.0 - initial release
// ============================================================================
module psum_adder_core #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4,
  parameter int NACC   = 1
) (
  input  logic             clk,
  input  logic             reset,
  psum_adder_core_if.slave bus
);

  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              SW       = DWIDTH + 10;
  localparam logic [SW-1:0]   SAT_MAX  = {{10{1'b0}}, {DWIDTH{1'b1}}};
  localparam logic [7:0]      LAST_RND = 8'(NACC - 1);
  localparam logic [AW:0]     CNT_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_EMIT  = 1'b1
  } state_t;

  logic [2:0][DWIDTH-1:0] in_data;
  logic [2:0][DWIDTH-1:0] head;
  logic [2:0]             in_valid;
  logic [2:0]             in_ready;
  logic [2:0]             push;
  logic [2:0]             q_full;
  logic [2:0]             q_empty;
  logic                   pop_all;

  assign in_data  = {bus.in2_data, bus.in1_data, bus.in0_data};
  assign in_valid = {bus.in2_valid, bus.in1_valid, bus.in0_valid};

  assign bus.in0_ready = in_ready[0];
  assign bus.in1_ready = in_ready[1];
  assign bus.in2_ready = in_ready[2];
  assign bus.q_full    = q_full;
  assign bus.q_empty   = q_empty;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_queue
      logic [DWIDTH-1:0] mem_q [DEPTH];
      logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
      logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
      logic [AW:0]       count_q, count_d;

      assign q_full[g]   = (count_q == CNT_FULL);
      assign q_empty[g]  = (count_q == '0);
      assign in_ready[g] = ~reset & ~q_full[g];
      assign push[g]     = in_valid[g] & in_ready[g];
      // Head is read from storage only, so a word becomes poppable one cycle after its push.
      assign head[g]     = mem_q[rd_ptr_q];

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push[g]) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_all) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push[g], pop_all})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
        end
      end

      always_ff @(posedge clk) begin
        if (push[g]) mem_q[wr_ptr_q] <= in_data[g];
      end
    end
  endgenerate

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] acc_q, acc_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic [7:0]        rnd_q, rnd_d;
  logic              out_valid_q, out_valid_d;
  logic [SW-1:0]     sum;
  logic [DWIDTH-1:0] acc_next;

  assign pop_all = (state_q == ST_ACCUM) & (&(~q_empty));

  always_comb begin
    sum         = SW'(head[0]) + SW'(head[1]) + SW'(head[2]) + SW'(acc_q);
    acc_next    = (sum > SAT_MAX) ? {DWIDTH{1'b1}} : sum[DWIDTH-1:0];
    state_d     = state_q;
    acc_d       = acc_q;
    rnd_d       = rnd_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_ACCUM: begin
        if (pop_all) begin
          if (rnd_q == LAST_RND) begin
            out_data_d  = acc_next;
            out_valid_d = 1'b1;
            acc_d       = '0;
            rnd_d       = '0;
            state_d     = ST_EMIT;
          end else begin
            acc_d = acc_next;
            rnd_d = rnd_q + 8'd1;
          end
        end
      end
      ST_EMIT: begin
        if (out_valid_q & bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      rnd_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rnd_q       <= rnd_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

endmodule
`default_nettype wire
